// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
// Sits between the processor data port and the dmem syncram. Addresses below
// MMIO_BASE pass through to dmem; addresses at or above MMIO_BASE reach local
// I/O registers (buttons, frame timer, LEDs). Read data from either side comes
// back exactly one cycle after the access, so the processor sees one port.
module dmem_mmio_bridge #(
  parameter logic [11:0] MMIO_BASE = 12'hF00,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned NUM_BTN   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        address_dmem,
  input  logic [31:0]        data,
  input  logic               wren,
  output logic [31:0]        q_dmem,
  output logic [11:0]        mem_address,
  output logic [31:0]        mem_data,
  output logic               mem_wren,
  input  logic [31:0]        mem_q,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [7:0]         leds,
  output logic               timer_irq
);

  // Register offsets relative to MMIO_BASE
  localparam logic [11:0] OFF_BTN_STATUS  = 12'h000;
  localparam logic [11:0] OFF_BTN_EVENT   = 12'h001;
  localparam logic [11:0] OFF_TIMER_COUNT = 12'h002;
  localparam logic [11:0] OFF_TIMER_CMP   = 12'h003;
  localparam logic [11:0] OFF_TIMER_FLAG  = 12'h004;
  localparam logic [11:0] OFF_LED         = 12'h005;

  // Prescaler width; TICK_DIV is at least 2 so the width is at least 1
  localparam int unsigned          PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]   PRESC_ONE = PRESC_W'(1'b1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic        is_io;
  logic [11:0] io_off;
  logic        io_wr;

  assign is_io  = (address_dmem >= MMIO_BASE);
  assign io_off = address_dmem - MMIO_BASE;
  assign io_wr  = wren & is_io;

  // dmem always sees the raw address and data; only the write strobe is gated
  assign mem_address = address_dmem;
  assign mem_data    = data;
  assign mem_wren    = wren & ~is_io;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q, btn_prev_q;
  logic [NUM_BTN-1:0] btn_event_q, btn_event_d;
  logic [1:0]         warm_q, warm_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               flag_q, flag_d;
  logic [7:0]         led_q, led_d;
  logic               rd_is_io_q;
  logic [31:0]        io_rdata_q;
  logic [31:0]        io_rdata;

  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_clr;
  logic               tick;
  logic [31:0]        count_inc;
  logic               flag_set;
  logic               flag_clr;

  // ---------------------------------------------------------------------------
  // Button synchronizer and edge capture
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer, then the edge flop loaded from the synchronized level
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_meta_q <= {NUM_BTN{1'b0}};
      btn_sync_q <= {NUM_BTN{1'b0}};
      btn_prev_q <= {NUM_BTN{1'b0}};
    end else begin
      btn_meta_q <= buttons;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  // Warm-up counter: after reset the chain refills from zero, so edges seen
  // while it refills come from buttons already held through reset, not presses
  always_comb begin
    if (warm_q == 2'd3) begin
      warm_d = warm_q;
    end else begin
      warm_d = warm_q + 2'd1;
    end
  end

  // Rising-edge detect and RW1C clear; a coinciding set wins over the clear
  always_comb begin
    btn_rise = btn_sync_q & ~btn_prev_q & {NUM_BTN{warm_q == 2'd3}};
    if (io_wr && (io_off == OFF_BTN_EVENT)) begin
      btn_clr = data[NUM_BTN-1:0];
    end else begin
      btn_clr = {NUM_BTN{1'b0}};
    end
    btn_event_d = btn_rise | (btn_event_q & ~btn_clr);
  end

  // ---------------------------------------------------------------------------
  // Frame timer
  // ---------------------------------------------------------------------------

  // Prescaler wraps at TICK_DIV-1; each wrap advances the 32-bit tick count
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    count_inc = count_q + 32'd1;
    if (tick) begin
      presc_d = {PRESC_W{1'b0}};
      count_d = count_inc;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      count_d = count_q;
    end
  end

  // Compare flag sets when the new count equals TIMER_CMP; set beats clear
  always_comb begin
    flag_set = tick && (count_inc == cmp_q);
    flag_clr = io_wr && (io_off == OFF_TIMER_FLAG) && data[0];
    flag_d   = flag_set | (flag_q & ~flag_clr);
  end

  // Plain RW registers: compare value and LEDs
  always_comb begin
    if (io_wr && (io_off == OFF_TIMER_CMP)) begin
      cmp_d = data;
    end else begin
      cmp_d = cmp_q;
    end
    if (io_wr && (io_off == OFF_LED)) begin
      led_d = data[7:0];
    end else begin
      led_d = led_q;
    end
  end

  // Register state for buttons, timer and LEDs
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_event_q <= {NUM_BTN{1'b0}};
      warm_q      <= 2'd0;
      presc_q     <= {PRESC_W{1'b0}};
      count_q     <= 32'd0;
      cmp_q       <= 32'hFFFF_FFFF;
      flag_q      <= 1'b0;
      led_q       <= 8'd0;
    end else begin
      btn_event_q <= btn_event_d;
      warm_q      <= warm_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      flag_q      <= flag_d;
      led_q       <= led_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // I/O read mux over the register state as it stands before the access edge
  always_comb begin
    io_rdata = 32'd0;
    case (io_off)
      OFF_BTN_STATUS:  io_rdata[NUM_BTN-1:0] = btn_sync_q;
      OFF_BTN_EVENT:   io_rdata[NUM_BTN-1:0] = btn_event_q;
      OFF_TIMER_COUNT: io_rdata = count_q;
      OFF_TIMER_CMP:   io_rdata = cmp_q;
      OFF_TIMER_FLAG:  io_rdata = {31'd0, flag_q};
      OFF_LED:         io_rdata = {24'd0, led_q};
      default:         io_rdata = 32'd0;
    endcase
  end

  // Capture the decode and the I/O snapshot on the same edge dmem samples its
  // address, giving both sides identical one-cycle latency
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_is_io_q <= 1'b0;
      io_rdata_q <= 32'd0;
    end else begin
      rd_is_io_q <= is_io;
      io_rdata_q <= io_rdata;
    end
  end

  // Return mux: I/O snapshot or the syncram output
  always_comb begin
    if (rd_is_io_q) begin
      q_dmem = io_rdata_q;
    end else begin
      q_dmem = mem_q;
    end
  end

  assign leds      = led_q;
  assign timer_irq = flag_q;

endmodule
